// File: rtl/conv_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_stream_if
// Purpose  : Start/image-read/result signal bundle of the conv_stream engine.
//            "master" is the convolution engine side, "slave" the environment
//            that supplies the start pulse and pixel memory and consumes results.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_stream_if;
  logic        i_start;
  logic        o_busy;
  logic [11:0] o_iaddr;
  logic [19:0] i_idata;
  logic        o_valid;
  logic [18:0] o_data;

  modport master (
    input  i_start,
    input  i_idata,
    output o_busy,
    output o_iaddr,
    output o_valid,
    output o_data
  );

  modport slave (
    output i_start,
    output i_idata,
    input  o_busy,
    input  o_iaddr,
    input  o_valid,
    input  o_data
  );
endinterface
`default_nettype wire

// File: rtl/conv_stream.sv
`default_nettype none
// ============================================================================
// Module   : conv_stream
// Purpose  : 64x64 two-kernel 3x3 convolution front end. Walks the image in
//            2x2 output blocks, 12-cycle frames, 8 results per frame, with a
//            double-buffered 4x4 window (active + shadow) and zero padding.
// Revision : 1.0 - initial release
// ============================================================================
module conv_stream #(
  parameter logic [179:0] K0 = 180'h0A89E_092D5_06D43_01004_F8F71_F6E54_FA6D7_FC834_FAC19,
  parameter logic [19:0]  B0 = 20'h01310,
  parameter logic [179:0] K1 = 180'hFDB55_02992_FC994_050FD_02F20_0202D_03BD7_FD369_05E68,
  parameter logic [19:0]  B1 = 20'hF7295
) (
  input  wire logic     clk,
  input  wire logic     reset,
  conv_stream_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREFETCH = 2'd1,
    S_RUN      = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  fstep;
  logic [9:0]  blk;
  logic        frame_end;
  logic        last_blk;

  // Fetch scheduling
  logic        fetch_on;
  logic [9:0]  tgt;
  logic        wrap;
  logic        slot_ok;
  logic [1:0]  win_i;
  logic [1:0]  win_j;
  logic        pad;
  logic        issue;
  logic [5:0]  row_addr;
  logic [5:0]  col_addr;

  // Read-return bookkeeping (data lands one cycle after the address)
  logic        pend;
  logic        pend_pad;
  logic [1:0]  pend_i;
  logic [1:0]  pend_j;

  // Window storage
  logic signed [19:0] shadow    [4][4];
  logic signed [19:0] shadow_nx [4][4];
  logic signed [19:0] act       [4][4];
  logic signed [19:0] load_win  [4][4];
  logic signed [19:0] win       [4][4];
  logic               wrap_cur;
  logic               first_step;

  // MAC datapath
  logic               kern;
  logic [1:0]         row_base;
  logic [1:0]         col_base;
  logic signed [19:0] pix;
  logic signed [19:0] wt;
  logic signed [39:0] prod;
  logic signed [43:0] acc;
  logic [19:0]        bias;
  logic [43:0]        bias_ext;
  logic [43:0]        acc_b;
  logic [19:0]        res;
  logic [18:0]        relu;
  logic               compute;

  // Output registers
  logic               valid_q;
  logic [18:0]        data_q;

  assign frame_end = (fstep == 4'd11);
  assign last_blk  = (blk == 10'd1023);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: start only accepted from idle
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (bus.i_start) state_nx = S_PREFETCH;
      S_PREFETCH: if (frame_end) state_nx = S_RUN;
      S_RUN:      if (frame_end && last_blk) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Frame step and block counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fstep <= 4'd0;
      blk   <= 10'd0;
    end else if (state == S_IDLE) begin
      fstep <= 4'd0;
      blk   <= 10'd0;
    end else begin
      fstep <= frame_end ? 4'd0 : fstep + 4'd1;
      if (state == S_RUN && frame_end) blk <= blk + 10'd1;
    end
  end

  // Fetch slot decode for the block after the current one (block 0 in PREFETCH)
  always_comb begin
    fetch_on = (state == S_PREFETCH) || (state == S_RUN && !last_blk);
    tgt      = (state == S_RUN) ? blk + 10'd1 : 10'd0;
    // A row wrap starts at col 0: col -1 is padding, three fresh columns needed
    wrap     = (tgt[4:0] == 5'd0);
    slot_ok  = wrap ? 1'b1 : !fstep[3];
    win_i    = fstep[1:0];
    win_j    = wrap ? (2'd1 + fstep[3:2]) : {1'b1, fstep[2]};
    // Window row i is image row 2R-1+i, window col j is image col 2C-1+j
    pad      = ((tgt[9:5] == 5'd0)  && (win_i == 2'd0)) ||
               ((tgt[9:5] == 5'd31) && (win_i == 2'd3)) ||
               ((tgt[4:0] == 5'd31) && (win_j == 2'd3));
    row_addr = {tgt[9:5], 1'b0} + {4'd0, win_i} - 6'd1;
    col_addr = {tgt[4:0], 1'b0} + {4'd0, win_j} - 6'd1;
    issue    = fetch_on && slot_ok;
  end

  assign bus.o_iaddr = (issue && !pad) ? {row_addr, col_addr} : 12'd0;
  assign bus.o_busy  = (state != S_IDLE);

  // Remember where the returning pixel belongs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend     <= 1'b0;
      pend_pad <= 1'b0;
      pend_i   <= 2'd0;
      pend_j   <= 2'd0;
    end else begin
      pend     <= issue;
      pend_pad <= pad;
      pend_i   <= win_i;
      pend_j   <= win_j;
    end
  end

  // Shadow with this cycle's returning pixel merged in (also the fstep-0 bypass)
  always_comb begin
    shadow_nx = shadow;
    if (pend) shadow_nx[pend_i][pend_j] = pend_pad ? 20'sd0 : bus.i_idata;
  end

  // Next active window: zero pad column on wrap, else reuse two columns
  always_comb begin
    wrap_cur   = (blk[4:0] == 5'd0);
    first_step = (state == S_RUN) && (fstep == 4'd0);
    for (int i = 0; i < 4; i++) begin
      if (wrap_cur) begin
        load_win[i][0] = 20'sd0;
        load_win[i][1] = shadow_nx[i][1];
      end else begin
        load_win[i][0] = act[i][2];
        load_win[i][1] = act[i][3];
      end
      load_win[i][2] = shadow_nx[i][2];
      load_win[i][3] = shadow_nx[i][3];
    end
  end

  // The MAC sees the freshly loaded window during fstep 0
  always_comb begin
    if (first_step) win = load_win;
    else            win = act;
  end

  // Window registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          shadow[i][j] <= 20'sd0;
          act[i][j]    <= 20'sd0;
        end
      end
    end else begin
      shadow <= shadow_nx;
      if (first_step) act <= load_win;
    end
  end

  // Single 9-tap MAC with bias, round-half-up and ReLU
  always_comb begin
    kern     = fstep[0];
    row_base = {1'b0, fstep[1]};
    col_base = {1'b0, fstep[2]};
    acc      = 44'sd0;
    pix      = 20'sd0;
    wt       = 20'sd0;
    prod     = 40'sd0;
    for (int tr = 0; tr < 3; tr++) begin
      for (int tc = 0; tc < 3; tc++) begin
        pix  = win[row_base + 2'(tr)][col_base + 2'(tc)];
        wt   = kern ? K1[179 - 20*(tr*3 + tc) -: 20] : K0[179 - 20*(tr*3 + tc) -: 20];
        prod = pix * wt;
        acc  = acc + {{4{prod[39]}}, prod};
      end
    end
    bias     = kern ? B1 : B0;
    bias_ext = {{8{bias[19]}}, bias, 16'd0};
    acc_b    = acc + bias_ext + 44'd32768;
    res      = 20'(acc_b >> 16);
    relu     = res[19] ? 19'd0 : res[18:0];
    compute  = (state == S_RUN) && !fstep[3];
  end

  // Registered result strobe, data forced to zero between strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= 19'd0;
    end else begin
      valid_q <= compute;
      data_q  <= compute ? relu : 19'd0;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;

endmodule
`default_nettype wire
